bg_mem_arbiter: RTL and testbench



---
 rtl/bg_arb_pkg.sv | 9 +
 rtl/bg_mem_fill_engine.sv | 56 +++++
 rtl/bg_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_bg_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_arb_pkg.sv
// Shared types and default sizes for the background-memory arbiter.
package bg_arb_pkg;
   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 16;
   localparam int MEM_WORDS  = 2 ** ADDR_W_DEF;

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/bg_mem_fill_engine.sv
// Whole-memory fill sequencer: writes one latched word to every address, ascending.
module bg_mem_fill_engine
   import bg_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fill_block,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data
);
   fill_state_t       state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] value;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         fill_done <= 1'b0;
      end else begin
         fill_done <= 1'b0;
         case (state)
            IDLE: if (fill_start) begin
               state <= FILL;
               cnt   <= '0;
            end
            FILL: begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  state     <= IDLE;
                  fill_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && fill_start)
         value <= fill_value;
   end

   // A start request blocks grants in its own cycle, before the state flips.
   assign fill_busy  = (state == FILL);
   assign fill_block = fill_busy | fill_start;
   assign fill_addr  = cnt;
   assign fill_data  = value;
endmodule

// File: rtl/bg_mem_arbiter.sv
// Two-requester round-robin arbiter onto a 1-cycle-latency memory port (s2).
// Optional whole-memory fill engine enabled by macro BG_ARB_FILL_EN.
module bg_mem_arbiter
   import bg_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   input  logic [DATA_W/8-1:0] a_be,
   output logic                a_gnt,
   output logic                a_rvalid,
   output logic [DATA_W-1:0]   a_rdata,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_wdata,
   input  logic [DATA_W/8-1:0] b_be,
   output logic                b_gnt,
   output logic                b_rvalid,
   output logic [DATA_W-1:0]   b_rdata,
   input  logic                fill_start,
   input  logic [DATA_W-1:0]   fill_value,
   output logic                fill_busy,
   output logic                fill_done,
   output logic [ADDR_W-1:0]   s2_address,
   output logic                s2_chipselect,
   output logic                s2_clken,
   output logic                s2_write,
   output logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_readdata
);
   req_id_t           last_grant;
   req_id_t           rd_id_p0;
   logic              rd_vld_p0;
   logic              fill_block;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_data;

`ifdef BG_ARB_FILL_EN
   bg_mem_fill_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fill (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .fill_start(fill_start),
      .fill_value(fill_value),
      .fill_busy (fill_busy),
      .fill_done (fill_done),
      .fill_block(fill_block),
      .fill_addr (fill_addr),
      .fill_data (fill_data)
   );
`else
   logic unused_fill;
   assign unused_fill = fill_start ^ (^fill_value);
   assign fill_busy   = 1'b0;
   assign fill_done   = 1'b0;
   assign fill_block  = 1'b0;
   assign fill_addr   = '0;
   assign fill_data   = '0;
`endif

   // The requester that did not win last time takes a contended cycle.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!fill_block) begin
         if (a_req && (!b_req || last_grant == REQ_B))
            a_gnt = 1'b1;
         else if (b_req)
            b_gnt = 1'b1;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         last_grant    <= REQ_B;
         s2_chipselect <= 1'b0;
         s2_write      <= 1'b0;
         s2_address    <= '0;
         s2_writedata  <= '0;
         s2_byteenable <= '0;
         rd_vld_p0     <= 1'b0;
         rd_id_p0      <= REQ_A;
         a_rvalid      <= 1'b0;
         b_rvalid      <= 1'b0;
      end else begin
         if (a_gnt)
            last_grant <= REQ_A;
         else if (b_gnt)
            last_grant <= REQ_B;

         // p0: command presented to s2; read tracked for its return
         rd_vld_p0 <= (a_gnt && !a_we) || (b_gnt && !b_we);
         rd_id_p0  <= b_gnt ? REQ_B : REQ_A;
         if (fill_busy) begin
            s2_chipselect <= 1'b1;
            s2_write      <= 1'b1;
            s2_address    <= fill_addr;
            s2_writedata  <= fill_data;
            s2_byteenable <= '1;
         end else if (a_gnt) begin
            s2_chipselect <= 1'b1;
            s2_write      <= a_we;
            s2_address    <= a_addr;
            s2_writedata  <= a_wdata;
            s2_byteenable <= a_be;
         end else if (b_gnt) begin
            s2_chipselect <= 1'b1;
            s2_write      <= b_we;
            s2_address    <= b_addr;
            s2_writedata  <= b_wdata;
            s2_byteenable <= b_be;
         end else begin
            s2_chipselect <= 1'b0;
            s2_write      <= 1'b0;
         end

         // p1: memory data returns, qualified to its owner
         a_rvalid <= rd_vld_p0 && (rd_id_p0 == REQ_A);
         b_rvalid <= rd_vld_p0 && (rd_id_p0 == REQ_B);
      end
   end

   assign s2_clken = ~reset_reset;
   assign a_rdata  = s2_readdata;
   assign b_rdata  = s2_readdata;
endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Directed bench for bg_mem_arbiter with a behavioural 1-cycle-latency memory.
module tb_bg_mem_arbiter;
   import bg_arb_pkg::*;
   localparam int AW = 13;
   localparam int DW = 16;
   localparam int NV = 14;

   logic          clk, reset_reset;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic [1:0]    a_be, b_be;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic          fill_start, fill_busy, fill_done;
   logic [DW-1:0] fill_value;
   logic [AW-1:0] s2_address;
   logic          s2_chipselect, s2_clken, s2_write;
   logic [DW-1:0] s2_writedata, s2_readdata;
   logic [1:0]    s2_byteenable;

   logic          init_mem, pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic a_req, a_we, b_req, b_we;
      logic exp_a, exp_b;
   } vec_t;
   vec_t vec [NV];

   bg_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_clk(clk), .reset_reset(reset_reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .fill_start(fill_start), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_clken(s2_clken),
      .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
      .s2_readdata(s2_readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] k);
      return DW'(k) ^ 16'hC3C3;
   endfunction
   function automatic logic [AW-1:0] a_addr_of(input int i, input logic we);
      return we ? AW'(13'h040 + i) : AW'(13'h010 + i);
   endfunction
   function automatic logic [AW-1:0] b_addr_of(input int i, input logic we);
      return we ? AW'(13'h060 + i) : AW'(13'h020 + i);
   endfunction

   // Memory model: registered read data, per-byte writes.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < (1 << AW); k++) mem[k] <= pattern(AW'(k));
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (s2_chipselect && s2_clken) begin
         if (s2_write) begin
            if (s2_byteenable[0]) mem[s2_address][7:0]  <= s2_writedata[7:0];
            if (s2_byteenable[1]) mem[s2_address][15:8] <= s2_writedata[15:8];
         end else begin
            s2_readdata <= mem[s2_address];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      pl_en = 1'b1; pl_addr = addr; pl_data = data;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, {a_gnt, b_gnt}, 0);
      chk({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
      chk({tag, "_cs_wr_clken"}, {s2_chipselect, s2_write, s2_clken}, 0);
      chk({tag, "_s2_addr"}, s2_address, 0);
      chk({tag, "_s2_wdata"}, s2_writedata, 0);
      chk({tag, "_s2_be"}, s2_byteenable, 0);
      chk({tag, "_fill"}, {fill_busy, fill_done}, 0);
   endtask

   task automatic read_a(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      a_req = 1'b1; a_we = 1'b0; a_addr = addr;
      #1 chk({name, "_gnt"}, a_gnt, 1);
      tick();
      a_req = 1'b0;
      tick();
      chk({name, "_rvalid"}, a_rvalid, 1);
      chk({name, "_rdata"}, a_rdata, exp);
   endtask

   initial begin
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [1:0]    e_be;
      int            busy, viol;

      clk = 0; reset_reset = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
      fill_start = 0; fill_value = '0;
      init_mem = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

      //          a_req a_we b_req b_we exp_a exp_b
      vec[0]  = '{1, 0, 1, 0, 1, 0};
      vec[1]  = '{1, 0, 1, 1, 0, 1};
      vec[2]  = '{1, 0, 1, 0, 1, 0};
      vec[3]  = '{1, 0, 1, 0, 0, 1};
      vec[4]  = '{1, 1, 0, 0, 1, 0};
      vec[5]  = '{1, 0, 0, 0, 1, 0};
      vec[6]  = '{0, 0, 1, 0, 0, 1};
      vec[7]  = '{0, 0, 0, 0, 0, 0};
      vec[8]  = '{1, 0, 1, 0, 1, 0};
      vec[9]  = '{1, 0, 0, 0, 1, 0};
      vec[10] = '{1, 0, 1, 0, 0, 1};
      vec[11] = '{0, 0, 0, 0, 0, 0};
      vec[12] = '{0, 0, 1, 0, 0, 1};
      vec[13] = '{1, 0, 1, 0, 1, 0};

      repeat (2) tick();
      init_mem = 1'b0;
      chk_all_zero("reset");
      reset_reset = 1'b0;
      #1 chk("clken_after_reset", s2_clken, 1);

      for (int i = 0; i < NV + 1; i++) begin
         if (i < NV) begin
            a_req = vec[i].a_req; a_we = vec[i].a_we; a_addr = a_addr_of(i, vec[i].a_we);
            a_wdata = DW'(16'hA000 + i); a_be = 2'b11;
            b_req = vec[i].b_req; b_we = vec[i].b_we; b_addr = b_addr_of(i, vec[i].b_we);
            b_wdata = DW'(16'hB000 + i); b_be = 2'b10;
            #1;
            chk($sformatf("vec%0d_a_gnt", i), a_gnt, vec[i].exp_a);
            chk($sformatf("vec%0d_b_gnt", i), b_gnt, vec[i].exp_b);
         end else begin
            a_req = 0; b_req = 0;
         end
         tick();
         if (i < NV) begin
            chk($sformatf("vec%0d_s2_cs", i), s2_chipselect, vec[i].exp_a | vec[i].exp_b);
            e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
            if (vec[i].exp_a) begin
               e_we = vec[i].a_we; e_addr = a_addr_of(i, e_we); e_wd = DW'(16'hA000 + i); e_be = 2'b11;
            end else if (vec[i].exp_b) begin
               e_we = vec[i].b_we; e_addr = b_addr_of(i, e_we); e_wd = DW'(16'hB000 + i); e_be = 2'b10;
            end
            chk($sformatf("vec%0d_s2_write", i), s2_write, e_we);
            if (vec[i].exp_a | vec[i].exp_b) begin
               chk($sformatf("vec%0d_s2_addr", i), s2_address, e_addr);
               chk($sformatf("vec%0d_s2_wdata", i), s2_writedata, e_wd);
               chk($sformatf("vec%0d_s2_be", i), s2_byteenable, e_be);
            end
         end
         if (i >= 1) begin
            chk($sformatf("vec%0d_a_rvalid", i - 1), a_rvalid, vec[i-1].exp_a & ~vec[i-1].a_we);
            chk($sformatf("vec%0d_b_rvalid", i - 1), b_rvalid, vec[i-1].exp_b & ~vec[i-1].b_we);
            if (vec[i-1].exp_a && !vec[i-1].a_we)
               chk($sformatf("vec%0d_a_rdata", i - 1), a_rdata, pattern(a_addr_of(i - 1, 0)));
            if (vec[i-1].exp_b && !vec[i-1].b_we)
               chk($sformatf("vec%0d_b_rdata", i - 1), b_rdata, pattern(b_addr_of(i - 1, 0)));
         end
      end
      tick();

      // Single read of a preloaded word: gnt at N, s2 at N+1, rvalid at N+2.
      preload(13'h0100, 16'hBEEF);
      preload(13'h1FFF, 16'hFFFF);
      a_req = 1; a_we = 0; a_addr = 13'h0100;
      #1 chk("beef_a_gnt", {a_gnt, b_gnt}, 2'b10);
      tick();
      a_req = 0;
      chk("beef_s2_addr", s2_address, 13'h0100);
      chk("beef_s2_cs_wr", {s2_chipselect, s2_write}, 2'b10);
      chk("beef_rvalid_early", a_rvalid, 0);
      tick();
      chk("beef_rvalid", {a_rvalid, b_rvalid}, 2'b10);
      chk("beef_a_rdata", a_rdata, 16'hBEEF);
      chk("beef_b_rdata_shared", b_rdata, 16'hBEEF);
      tick();
      chk("beef_rvalid_once", a_rvalid, 0);

      // Byte-masked write from B, read back by A.
      b_req = 1; b_we = 1; b_addr = 13'h1FFF; b_wdata = 16'h1234; b_be = 2'b01;
      #1 chk("bwr_b_gnt", b_gnt, 1);
      tick();
      b_req = 0; b_we = 0;
      chk("bwr_s2_be", s2_byteenable, 2'b01);
      chk("bwr_s2_write", s2_write, 1);
      chk("bwr_s2_wdata", s2_writedata, 16'h1234);
      read_a("bwr_readback", 13'h1FFF, 16'hFF34);
      chk("bwr_low_byte", a_rdata[7:0], 8'h34);
      chk("bwr_no_b_rvalid", b_rvalid, 0);
      tick();

`ifdef BG_ARB_FILL_EN
      a_req = 1; a_we = 0; a_addr = 13'h0007; fill_value = 16'hA5A5; fill_start = 1;
      #1 chk("fill_start_blocks_gnt", a_gnt, 0);
      tick();
      fill_start = 0; fill_value = 16'h0000;
      busy = 0; viol = 0;
      while (fill_busy && busy < 9000) begin
         if (a_gnt || b_gnt || fill_done) viol++;
         if (busy == 1) begin
            chk("fill_first_addr", s2_address, 0);
            chk("fill_first_write", {s2_chipselect, s2_write, s2_byteenable}, 4'b1111);
            chk("fill_first_data", s2_writedata, 16'hA5A5);
         end
         if (busy == 100) fill_start = 1;
         if (busy == 101) fill_start = 0;
         busy++;
         tick();
      end
      chk("fill_busy_cycles", busy, MEM_WORDS);
      chk("fill_no_gnt_while_busy", viol, 0);
      chk("fill_done_pulse", fill_done, 1);
      chk("fill_then_a_gnt", a_gnt, 1);
      tick();
      a_req = 0;
      chk("fill_done_single", fill_done, 0);
      chk("fill_busy_clear", fill_busy, 0);
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         read_a($sformatf("fill_rd%0d", k), AW'($urandom_range(0, (1 << AW) - 1)), 16'hA5A5);
         tick();
      end
`else
      a_req = 1; a_we = 0; a_addr = 13'h0005; fill_value = 16'hA5A5; fill_start = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("nofill_gnt%0d", k), a_gnt, 1);
         chk($sformatf("nofill_busy%0d", k), {fill_busy, fill_done}, 0);
         tick();
         fill_start = 0;
      end
      a_req = 0;
`endif
      repeat (3) tick();

      // Reset one cycle after a B read grant discards the read.
      b_req = 1; b_we = 0; b_addr = 13'h0022;
      #1 chk("rst_b_gnt", b_gnt, 1);
      tick();
      b_req = 0;
      chk("rst_pre_s2_addr", s2_address, 13'h0022);
      reset_reset = 1;
      #1 chk_all_zero("midrst");
      repeat (2) tick();
      reset_reset = 0;
      viol = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (b_rvalid || a_rvalid || s2_chipselect || fill_done) viol++;
         tick();
      end
      chk("rst_no_late_rvalid", viol, 0);
      chk("rst_clken_back", s2_clken, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
